// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: default geometry, read-mode
// selectors and the occupancy-width helper.
package fifo_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 8;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Occupancy spans 0..DEPTH inclusive, so it needs one bit beyond the address.
    function automatic int countWidth(input int ptrAddr);
        return ptrAddr + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the FIFO: one synchronous write port and one
// combinational read port. Contents are deliberately never cleared.
module fifo_mem #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int PTR_ADDR = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [PTR_ADDR-1:0] waddr_i,
    input  logic [WIDTH-1:0]    wdata_i,
    input  logic [PTR_ADDR-1:0] raddr_i,
    output logic [WIDTH-1:0]    rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky-free error pulses and a selectable first-word-fall-through read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int PTR_ADDR  = $clog2(DEPTH),
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = MODE_STD
) (
    input  logic                                clk_i,
    input  logic                                clr_i,
    input  logic                                wr_en_i,
    input  logic [WIDTH-1:0]                    wdata_i,
    input  logic                                rd_en_i,
    output logic [WIDTH-1:0]                    rdata_o,
    output logic                                full_o,
    output logic                                empty_o,
    output logic                                almost_full_o,
    output logic                                almost_empty_o,
    output logic [countWidth(PTR_ADDR)-1:0]     count_o,
    output logic                                wr_error_o,
    output logic                                rd_error_o
);

    localparam int CNT_W = countWidth(PTR_ADDR);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    logic [PTR_ADDR:0] wrPtr_q, wrPtr_d;
    logic [PTR_ADDR:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wrError_q, wrError_d;
    logic              rdError_q, rdError_d;

    logic              wrAccept;
    logic              rdAccept;
    logic [WIDTH-1:0]  memRdata;

    // Flags come straight from the registered count so they never lag it.
    assign full_o         = (count_q == DEPTH_C);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= AF_C);
    assign almost_empty_o = (count_q <= AE_C);
    assign count_o        = count_q;
    assign wr_error_o     = wrError_q;
    assign rd_error_o     = rdError_q;

    assign wrAccept = wr_en_i && !full_o;
    assign rdAccept = rd_en_i && !empty_o;

    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        wrError_d = wr_en_i && full_o;
        rdError_d = rd_en_i && empty_o;

        if (wrAccept) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (rdAccept) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end

        unique case ({wrAccept, rdAccept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            wrError_q <= 1'b0;
            rdError_q <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            wrError_q <= wrError_d;
            rdError_q <= rdError_d;
        end
    end

    // The wrap bits make the pointer difference equal the occupancy modulo 2*DEPTH.
    always @(posedge clk_i) begin
        if (!clr_i) begin
            assert (CNT_W'(wrPtr_q - rdPtr_q) == count_q);
        end
    end

    fifo_mem #(
        .DEPTH   (DEPTH),
        .WIDTH   (WIDTH),
        .PTR_ADDR(PTR_ADDR)
    ) u_mem (
        .clk_i  (clk_i),
        .we_i   (wrAccept && !clr_i),
        .waddr_i(wrPtr_q[PTR_ADDR-1:0]),
        .wdata_i(wdata_i),
        .raddr_i(rdPtr_q[PTR_ADDR-1:0]),
        .rdata_o(memRdata)
    );

    if (FWFT == MODE_FWFT) begin : g_fwft
        assign rdata_o = empty_o ? '0 : memRdata;
    end else begin : g_std
        logic [WIDTH-1:0] rdData_q, rdData_d;

        always_comb begin
            rdData_d = rdData_q;
            if (rdAccept) begin
                rdData_d = memRdata;
            end
        end

        always_ff @(posedge clk_i) begin
            if (clr_i) begin
                rdData_q <= '0;
            end else begin
                rdData_q <= rdData_d;
            end
        end

        assign rdata_o = rdData_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench driving a standard-read and an FWFT instance with identical
// stimulus and comparing against hand-derived expectations.
module tb_sync_fifo_param;

    logic       clk_i = 1'b0;
    logic       clr_i;
    logic       wr_en_i;
    logic [7:0] wdata_i;
    logic       rd_en_i;

    logic [7:0] rdataS, rdataF;
    logic       fullS, emptyS, afS, aeS, wrErrS, rdErrS;
    logic       fullF, emptyF, afF, aeF, wrErrF, rdErrF;
    logic [4:0] countS, countF;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk_i = ~clk_i;

    sync_fifo_param #(
        .DEPTH(16), .WIDTH(8), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)
    ) dutStd (
        .clk_i(clk_i), .clr_i(clr_i), .wr_en_i(wr_en_i), .wdata_i(wdata_i),
        .rd_en_i(rd_en_i), .rdata_o(rdataS), .full_o(fullS), .empty_o(emptyS),
        .almost_full_o(afS), .almost_empty_o(aeS), .count_o(countS),
        .wr_error_o(wrErrS), .rd_error_o(rdErrS)
    );

    sync_fifo_param #(
        .DEPTH(16), .WIDTH(8), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)
    ) dutFwft (
        .clk_i(clk_i), .clr_i(clr_i), .wr_en_i(wr_en_i), .wdata_i(wdata_i),
        .rd_en_i(rd_en_i), .rdata_o(rdataF), .full_o(fullF), .empty_o(emptyF),
        .almost_full_o(afF), .almost_empty_o(aeF), .count_o(countF),
        .wr_error_o(wrErrF), .rd_error_o(rdErrF)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic clr, input logic wr, input logic [7:0] wd, input logic rd);
        clr_i   = clr;
        wr_en_i = wr;
        wdata_i = wd;
        rd_en_i = rd;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        clr_i = 1'b1; wr_en_i = 1'b0; wdata_i = 8'h00; rd_en_i = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("rst_count", countS, 0);
        checkOutput("rst_empty", emptyS, 1);
        checkOutput("rst_ae", aeS, 1);
        checkOutput("rst_full", fullS, 0);
        checkOutput("rst_af", afS, 0);
        checkOutput("rst_wrerr", wrErrS, 0);
        checkOutput("rst_rderr", rdErrS, 0);
        checkOutput("rst_rdata", rdataS, 0);
        checkOutput("rst_rdataF", rdataF, 0);

        // Fill with 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
            checkOutput("fill_count", countS, i + 1);
            checkOutput("fill_af", afS, (i + 1 >= 14) ? 1 : 0);
            checkOutput("fill_ae", aeS, (i + 1 <= 2) ? 1 : 0);
            checkOutput("fill_full", fullS, (i == 15) ? 1 : 0);
            checkOutput("fill_headF", rdataF, 8'h00);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 8'hEE, 1'b0);
            checkOutput("ovf_wrerr", wrErrS, 1);
            checkOutput("ovf_count", countS, 16);
            checkOutput("ovf_full", fullS, 1);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("ovf_wrerr_clear", wrErrS, 0);

        // Drain, checking order and read latency
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("drain_rdata", rdataS, i);
            checkOutput("drain_count", countS, 15 - i);
            checkOutput("drain_headF", rdataF, (i == 15) ? 0 : i + 1);
        end
        checkOutput("drain_empty", emptyS, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("udf_rderr", rdErrS, 1);
            checkOutput("udf_rdata_hold", rdataS, 8'h0F);
            checkOutput("udf_count", countS, 0);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("udf_rderr_clear", rdErrS, 0);

        // Simultaneous read/write at occupancy 8
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        checkOutput("sim_pre_count", countS, 8);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'h18 + k), 1'b1);
            checkOutput("sim_count", countS, 8);
            checkOutput("sim_rdata", rdataS, 8'h10 + k);
            checkOutput("sim_headF", rdataF, 8'h11 + k);
            checkOutput("sim_errs", {wrErrS, rdErrS}, 0);
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("sim_tail", rdataS, 8'h24 + k);
        end
        checkOutput("sim_empty", emptyS, 1);

        // First-word fall-through visibility and pop
        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0);
        checkOutput("fwft_rdata", rdataF, 8'hA5);
        checkOutput("fwft_nonempty", emptyF, 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("fwft_pop_empty", emptyF, 1);
        checkOutput("fwft_pop_rdata", rdataF, 0);
        checkOutput("fwft_std_rdata", rdataS, 8'hA5);

        // Wrap-around across two batches, then reset mid-operation
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("wrap1_rdata", rdataS, 8'h30 + i);
        end
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        checkOutput("wrap2_full", fullS, 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("wrap2_rdata", rdataS, 8'h40 + i);
        end
        checkOutput("wrap2_count", countS, 6);
        applyStimulus(1'b1, 1'b1, 8'h99, 1'b0);
        checkOutput("midrst_count", countS, 0);
        checkOutput("midrst_empty", emptyS, 1);
        checkOutput("midrst_rdata", rdataS, 0);
        checkOutput("midrst_rdataF", rdataF, 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("midrst_rderr", rdErrS, 1);
        checkOutput("midrst_count2", countS, 0);

        // Write and read together while empty: write lands, read is rejected
        applyStimulus(1'b0, 1'b1, 8'h5A, 1'b1);
        checkOutput("emptyrw_count", countS, 1);
        checkOutput("emptyrw_rderr", rdErrS, 1);
        checkOutput("emptyrw_headF", rdataF, 8'h5A);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("emptyrw_rdata", rdataS, 8'h5A);
        checkOutput("emptyrw_rderr_clear", rdErrS, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
